// File: rtl/seg7_score_scanner_pkg.sv
// rtl/seg7_score_scanner_pkg.sv - shared constants, FSM encoding and blanking helper for the score scanner
package seg7_score_scanner_pkg;

    localparam int BCD_DIGITS = 4;

    // Active-low anode codes: all off, and one code per digit position
    localparam logic [3:0] SEG_OFF = 4'b1111;
    localparam logic [3:0] DIGIT_SEL [BCD_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // A digit above position 0 is a leading zero when it and every higher nibble are zero
    function automatic logic blank_slot(input logic [15:0] bcd, input logic [1:0] digit);
        case (digit)
            2'd1:    blank_slot = (bcd[15:4] == 12'd0);
            2'd2:    blank_slot = (bcd[15:8] == 8'd0);
            2'd3:    blank_slot = (bcd[15:12] == 4'd0);
            default: blank_slot = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/Seg7Display.sv
// rtl/Seg7Display.sv - digit decoder: digit index to anode select, nibble to active-low cathodes plus dot
module Seg7Display
    import seg7_score_scanner_pkg::*;
(
    input  logic [1:0] SEG_SELECT_IN,
    input  logic [3:0] BIN_IN,
    input  logic       DOT_IN,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT
);

    assign SEG_SELECT_OUT = DIGIT_SEL[SEG_SELECT_IN];

    // Hex glyph table, segments g..a in bits 6..0, active low
    always_comb begin
        HEX_OUT[7] = DOT_IN;
        case (BIN_IN)
            4'h0:    HEX_OUT[6:0] = 7'b1000000;
            4'h1:    HEX_OUT[6:0] = 7'b1111001;
            4'h2:    HEX_OUT[6:0] = 7'b0100100;
            4'h3:    HEX_OUT[6:0] = 7'b0110000;
            4'h4:    HEX_OUT[6:0] = 7'b0011001;
            4'h5:    HEX_OUT[6:0] = 7'b0010010;
            4'h6:    HEX_OUT[6:0] = 7'b0000010;
            4'h7:    HEX_OUT[6:0] = 7'b1111000;
            4'h8:    HEX_OUT[6:0] = 7'b0000000;
            4'h9:    HEX_OUT[6:0] = 7'b0011000;
            4'hA:    HEX_OUT[6:0] = 7'b0001000;
            4'hB:    HEX_OUT[6:0] = 7'b0000011;
            4'hC:    HEX_OUT[6:0] = 7'b1000110;
            4'hD:    HEX_OUT[6:0] = 7'b0100001;
            4'hE:    HEX_OUT[6:0] = 7'b0000110;
            default: HEX_OUT[6:0] = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/bcd_shift_step.sv
// rtl/bcd_shift_step.sv - one double-dabble iteration: add 3 to nibbles >= 5, then shift in one bit
module bcd_shift_step
    import seg7_score_scanner_pkg::*;
(
    input  logic [15:0] scratch_in,
    input  logic        bit_in,
    output logic [15:0] scratch_out
);

    logic [15:0] adjusted;

    // Correct every nibble that would overflow past 9 once doubled
    always_comb begin
        adjusted = scratch_in;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (scratch_in[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_in[4*i +: 4] + 4'd3;
            end
        end
    end

    assign scratch_out = {adjusted[14:0], bit_in};

endmodule

// File: rtl/seg7_score_scanner.sv
// rtl/seg7_score_scanner.sv - serial binary-to-BCD conversion and 4-digit multiplexed display scan
module seg7_score_scanner
    import seg7_score_scanner_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int IN_WIDTH  = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [IN_WIDTH-1:0] SCORE_IN,
    input  logic                SCORE_VALID,
    input  logic                BLANK_LEADING,
    input  logic [3:0]          DOT_MASK,
    output logic                BUSY,
    output logic [3:0]          SEG_SELECT_OUT,
    output logic [7:0]          HEX_OUT
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [IN_WIDTH-1:0] MAX_W   = IN_WIDTH'(MAX_SCORE);
    localparam logic [PW-1:0]       PRE_TOP = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]       CNT_TOP = CW'(IN_WIDTH - 1);

    state_t              state;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [CW-1:0]       shift_cnt;
    logic [15:0]         scratch;
    logic [15:0]         scratch_next;
    logic [15:0]         disp_bcd;
    logic [PW-1:0]       prescaler;
    logic [1:0]          digit_cnt;
    logic [3:0]          nibble;
    logic                dot_n;
    logic [3:0]          dec_select;

    bcd_shift_step u_step (
        .scratch_in  (scratch),
        .bit_in      (shift_reg[IN_WIDTH-1]),
        .scratch_out (scratch_next)
    );

    // Conversion sequencer; the display register only changes in COMMIT so partial results never show
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            BUSY      <= 1'b0;
            shift_reg <= '0;
            shift_cnt <= '0;
            scratch   <= '0;
            disp_bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (SCORE_VALID) begin
                        shift_reg <= (SCORE_IN > MAX_W) ? MAX_W : SCORE_IN;
                        scratch   <= '0;
                        shift_cnt <= '0;
                        BUSY      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    scratch   <= scratch_next;
                    shift_reg <= shift_reg << 1;
                    shift_cnt <= shift_cnt + 1'b1;
                    if (shift_cnt == CNT_TOP) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_bcd <= scratch;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running digit scan, independent of loads and conversion
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prescaler <= '0;
            digit_cnt <= '0;
        end else if (prescaler == PRE_TOP) begin
            prescaler <= '0;
            digit_cnt <= digit_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign nibble = disp_bcd[{digit_cnt, 2'b00} +: 4];
    assign dot_n  = ~DOT_MASK[digit_cnt];

    Seg7Display u_display (
        .SEG_SELECT_IN  (digit_cnt),
        .BIN_IN         (nibble),
        .DOT_IN         (dot_n),
        .SEG_SELECT_OUT (dec_select),
        .HEX_OUT        (HEX_OUT)
    );

    assign SEG_SELECT_OUT = (BLANK_LEADING && blank_slot(disp_bcd, digit_cnt)) ? SEG_OFF : dec_select;

endmodule

// File: tb/tb_seg7_score_scanner.sv
// tb/tb_seg7_score_scanner.sv - self-checking bench for seg7_score_scanner with a decimal reference model
module tb_seg7_score_scanner;

    localparam int SCAN_DIV = 4;
    localparam int IN_WIDTH = 14;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic [IN_WIDTH-1:0] SCORE_IN = '0;
    logic                SCORE_VALID = 1'b0;
    logic                BLANK_LEADING = 1'b0;
    logic [3:0]          DOT_MASK = 4'b0000;
    logic                BUSY;
    logic [3:0]          SEG_SELECT_OUT;
    logic [7:0]          HEX_OUT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int shown = 0;

    int         p10 [4]    = '{1, 10, 100, 1000};
    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    seg7_score_scanner #(.SCAN_DIV(SCAN_DIV), .IN_WIDTH(IN_WIDTH), .MAX_SCORE(9999)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SCORE_IN       (SCORE_IN),
        .SCORE_VALID    (SCORE_VALID),
        .BLANK_LEADING  (BLANK_LEADING),
        .DOT_MASK       (DOT_MASK),
        .BUSY           (BUSY),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycles since reset release give the scan slot directly
    task automatic tick;
        @(posedge CLK);
        if (RESET) cyc = 0;
        else cyc++;
        #1;
    endtask

    task automatic check_display(input string tag);
        int   d;
        int   n;
        logic blank;
        logic [3:0] sel;
        d     = (cyc / SCAN_DIV) % 4;
        n     = (shown / p10[d]) % 10;
        blank = BLANK_LEADING && (d > 0) && (shown < p10[d]);
        sel   = blank ? 4'b1111 : ~(4'b0001 << d);
        chk({tag, "_sel"}, 32'(SEG_SELECT_OUT), 32'(sel));
        chk({tag, "_hex"}, 32'(HEX_OUT), 32'({~DOT_MASK[d], glyph[n]}));
    endtask

    task automatic watch(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick;
            chk({tag, "_idle"}, 32'(BUSY), 32'd0);
            check_display(tag);
        end
    endtask

    // One load; optional extra VALID pulse or RESET at a given busy cycle (0 = none)
    task automatic do_load(input int v, input int inject_at, input int inject_val,
                           input int reset_at, input string tag);
        SCORE_IN    = IN_WIDTH'(v);
        SCORE_VALID = 1'b1;
        tick;
        SCORE_VALID = 1'b0;
        chk({tag, "_busy_e0"}, 32'(BUSY), 32'd1);
        check_display({tag, "_hold"});
        for (int k = 1; k <= 15; k++) begin
            if (k == reset_at) begin
                RESET = 1'b1;
                tick;
                RESET = 1'b0;
                shown = 0;
                chk({tag, "_busy_rst"}, 32'(BUSY), 32'd0);
                check_display({tag, "_rst"});
                return;
            end
            if (k == inject_at) begin
                SCORE_IN    = IN_WIDTH'(inject_val);
                SCORE_VALID = 1'b1;
            end
            tick;
            SCORE_VALID = 1'b0;
            if (k < 15) begin
                chk({tag, "_busy"}, 32'(BUSY), 32'd1);
            end else begin
                shown = (v > 9999) ? 9999 : v;
                chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
            end
            check_display({tag, "_conv"});
        end
    endtask

    initial begin
        // Reset held 3 cycles
        repeat (3) tick;
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_sel", 32'(SEG_SELECT_OUT), 32'h0000000e);
        chk("reset_hex", 32'(HEX_OUT), 32'h000000c0);
        RESET = 1'b0;
        watch(4, "post_reset");

        // Plain conversion, all four slots
        do_load(1234, 0, 0, 0, "l1234");
        watch(20, "s1234");

        // Saturation
        DOT_MASK = 4'b0101;
        do_load(12000, 0, 0, 0, "l12000");
        watch(20, "s9999");

        // Leading-zero blanking
        DOT_MASK = 4'b0000;
        BLANK_LEADING = 1'b1;
        do_load(42, 0, 0, 0, "l42");
        watch(20, "s42");
        do_load(0, 0, 0, 0, "l0");
        watch(20, "s0");
        BLANK_LEADING = 1'b0;

        // Request during conversion is ignored
        do_load(5678, 4, 5555, 0, "l5678");
        watch(24, "s5678");

        // Reset mid-conversion
        do_load(9999, 0, 0, 7, "l9999rst");
        watch(20, "srst");

        // VALID held high: re-accepted 16 cycles after the first accept
        SCORE_IN    = IN_WIDTH'(77);
        SCORE_VALID = 1'b1;
        tick;
        chk("held_e0", 32'(BUSY), 32'd1);
        repeat (14) tick;
        tick;
        chk("held_e15", 32'(BUSY), 32'd0);
        tick;
        chk("held_e16", 32'(BUSY), 32'd1);
        SCORE_VALID = 1'b0;
        repeat (15) tick;
        chk("held_done", 32'(BUSY), 32'd0);
        shown = 77;
        watch(16, "s77");

        // Randomized loads
        for (int r = 0; r < 10; r++) begin
            BLANK_LEADING = 1'($urandom_range(0, 1));
            DOT_MASK      = 4'($urandom_range(0, 15));
            do_load(int'($urandom_range(0, 16383)), 0, 0, 0, "lrand");
            watch(18, "srand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
